// File: rtl/parallel_bus_arbiter.sv
// Two-master, one-slave parallel bus arbiter with registered grant and
// round-robin tie-break; the owner's request passes straight through to the slave.
module parallel_bus_arbiter #(
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_bus,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] m0_address,
  input  logic [DATA_WIDTH-1:0] m0_data_i,
  input  logic                  m0_read,
  input  logic                  m0_write,
  output logic [DATA_WIDTH-1:0] m0_data_o,
  output logic                  m0_stall,
  input  logic [ADDR_WIDTH-1:0] m1_address,
  input  logic [DATA_WIDTH-1:0] m1_data_i,
  input  logic                  m1_read,
  input  logic                  m1_write,
  output logic [DATA_WIDTH-1:0] m1_data_o,
  output logic                  m1_stall,
  output logic [ADDR_WIDTH-1:0] s_address,
  output logic [DATA_WIDTH-1:0] s_data_o,
  output logic                  s_read,
  output logic                  s_write,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  input  logic                  s_stall,
  output logic [1:0]            owner
);

  // Encoding doubles as the owner code, so owner needs no decode logic.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    G0   = 2'b01,
    G1   = 2'b10
  } grant_t;

  grant_t grant_q, grant_d;
  logic   last_q, last_d;  // 0: m0 completed last, 1: m1 completed last
  logic   req0, req1;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_bus) begin
    if (rst) begin
      grant_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    grant_d   = grant_q;
    last_d    = last_q;
    s_address = '0;
    s_data_o  = '0;
    s_read    = 1'b0;
    s_write   = 1'b0;
    m0_stall  = req0;
    m1_stall  = req1;

    unique case (grant_q)
      IDLE: begin
        if (req0 && (!req1 || last_q)) grant_d = G0;
        else if (req1)                 grant_d = G1;
      end
      G0: begin
        s_address = m0_address;
        s_data_o  = m0_data_i;
        s_read    = m0_read;
        s_write   = m0_write;
        m0_stall  = s_stall;
        if (!req0) begin
          grant_d = IDLE;          // abort leaves fairness history untouched
        end else if (!s_stall) begin
          grant_d = IDLE;
          last_d  = 1'b0;
        end
      end
      G1: begin
        s_address = m1_address;
        s_data_o  = m1_data_i;
        s_read    = m1_read;
        s_write   = m1_write;
        m1_stall  = s_stall;
        if (!req1) begin
          grant_d = IDLE;
        end else if (!s_stall) begin
          grant_d = IDLE;
          last_d  = 1'b1;
        end
      end
      default: grant_d = IDLE;
    endcase
  end

  assign m0_data_o = s_data_i;
  assign m1_data_o = s_data_i;
  assign owner     = grant_q;

endmodule

// File: tb/tb_parallel_bus_arbiter.sv
// Directed bench for parallel_bus_arbiter: hand-computed owner, strobe, mux and
// stall expectations across single, tie, late-arrival, back-to-back, abort and reset cases.
module tb_parallel_bus_arbiter;

  localparam int AW = 24;
  localparam int DW = 32;

  logic          clk_bus = 1'b0;
  logic          rst;
  logic [AW-1:0] m0_address, m1_address, s_address;
  logic [DW-1:0] m0_data_i, m1_data_i, m0_data_o, m1_data_o, s_data_o, s_data_i;
  logic          m0_read, m0_write, m1_read, m1_write, m0_stall, m1_stall;
  logic          s_read, s_write, s_stall;
  logic [1:0]    owner;

  int n_checks = 0;
  int n_fail   = 0;

  parallel_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_bus    (clk_bus),
    .rst        (rst),
    .m0_address (m0_address),
    .m0_data_i  (m0_data_i),
    .m0_read    (m0_read),
    .m0_write   (m0_write),
    .m0_data_o  (m0_data_o),
    .m0_stall   (m0_stall),
    .m1_address (m1_address),
    .m1_data_i  (m1_data_i),
    .m1_read    (m1_read),
    .m1_write   (m1_write),
    .m1_data_o  (m1_data_o),
    .m1_stall   (m1_stall),
    .s_address  (s_address),
    .s_data_o   (s_data_o),
    .s_read     (s_read),
    .s_write    (s_write),
    .s_data_i   (s_data_i),
    .s_stall    (s_stall),
    .owner      (owner)
  );

  always #5 clk_bus = ~clk_bus;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 ns after the rising edge; checks follow 2 ns later.
  task automatic tick();
    @(posedge clk_bus);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic idle_inputs();
    m0_read = 1'b0; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
    s_stall = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    m0_address = '0; m1_address = '0; m0_data_i = '0; m1_data_i = '0;
    s_data_i = '0;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
    settle();
    check("reset_owner",  owner,   32'h0);
    check("reset_sread",  s_read,  32'h0);
    check("reset_saddr",  s_address, 32'h0);
    check("reset_m0stall", m0_stall, 32'h0);

    // Single read with four slave stall cycles
    m0_read = 1'b1; m0_address = 24'h000100; s_stall = 1'b1;
    settle();
    check("t1_c0_m0stall", m0_stall, 32'h1);
    check("t1_c0_sread",   s_read,   32'h0);
    for (int c = 1; c <= 4; c++) begin
      tick(); settle();
      check("t1_stall_sread", s_read,   32'h1);
      check("t1_stall_owner", owner,    32'h1);
      check("t1_stall_m0st",  m0_stall, 32'h1);
    end
    tick();
    s_stall = 1'b0; s_data_i = 32'hDEADBEEF;
    settle();
    check("t1_c5_sread",   s_read,    32'h1);
    check("t1_c5_saddr",   s_address, 32'h000100);
    check("t1_c5_m0stall", m0_stall,  32'h0);
    check("t1_c5_data",    m0_data_o, 32'hDEADBEEF);
    check("t1_c5_m1data",  m1_data_o, 32'hDEADBEEF);
    tick();
    m0_read = 1'b0;
    settle();
    check("t1_c6_owner",   owner,  32'h0);
    check("t1_c6_sread",   s_read, 32'h0);

    // Tie after reset, then strict alternation over four transfers
    do_reset();
    m0_read = 1'b1; m0_address = 24'h000300;
    m1_write = 1'b1; m1_address = 24'h000200; m1_data_i = 32'h12345678;
    s_stall = 1'b0;
    settle();
    check("t2_c0_m0stall", m0_stall, 32'h1);
    check("t2_c0_m1stall", m1_stall, 32'h1);
    for (int k = 0; k < 4; k++) begin
      tick(); settle();
      check("t2_grant_owner", owner, (k % 2 == 0) ? 32'h1 : 32'h2);
      if (k % 2 == 0) begin
        check("t2_g0_sread",   s_read,    32'h1);
        check("t2_g0_saddr",   s_address, 32'h000300);
        check("t2_g0_m1stall", m1_stall,  32'h1);
      end else begin
        check("t2_g1_swrite",  s_write,   32'h1);
        check("t2_g1_saddr",   s_address, 32'h000200);
        check("t2_g1_sdata",   s_data_o,  32'h12345678);
        check("t2_g1_m0stall", m0_stall,  32'h1);
        check("t2_g1_m1stall", m1_stall,  32'h0);
      end
      tick(); settle();
      check("t2_bubble_owner", owner, 32'h0);
    end
    idle_inputs();

    // Late arrival: m0 rises while m1 write is stalled by the slave
    m1_write = 1'b1; m1_address = 24'h000400; m1_data_i = 32'hA5A5A5A5;
    s_stall = 1'b1;
    tick(); settle();
    check("t3_c1_owner", owner, 32'h2);
    tick();
    m0_read = 1'b1; m0_address = 24'h000500;
    settle();
    check("t3_c2_m0stall", m0_stall,  32'h1);
    check("t3_c2_saddr",   s_address, 32'h000400);
    check("t3_c2_sread",   s_read,    32'h0);
    tick(); settle();
    check("t3_c3_owner",   owner,     32'h2);
    tick();
    s_stall = 1'b0;
    settle();
    check("t3_c4_m1stall", m1_stall,  32'h0);
    check("t3_c4_m0stall", m0_stall,  32'h1);
    tick();
    m1_write = 1'b0;
    settle();
    check("t3_c5_owner",   owner,     32'h0);
    check("t3_c5_m0stall", m0_stall,  32'h1);
    tick(); settle();
    check("t3_c6_owner",   owner,     32'h1);
    check("t3_c6_saddr",   s_address, 32'h000500);
    tick();
    idle_inputs();
    settle();

    // Back-to-back transfers from m1 alone
    m1_write = 1'b1; m1_address = 24'h000600; m1_data_i = 32'h0BADF00D;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 4) m1_write = 1'b0;
      settle();
      check("t4_swrite", s_write, (c % 2 == 1) ? 32'h1 : 32'h0);
      check("t4_owner",  owner,   (c % 2 == 1) ? 32'h2 : 32'h0);
    end

    // Abort keeps last = m1, so the following tie goes to m0 again
    do_reset();
    m0_read = 1'b1; m0_address = 24'h000700; s_stall = 1'b1;
    tick(); settle();
    check("t5_c1_owner", owner, 32'h1);
    tick();
    m0_read = 1'b0;
    settle();
    check("t5_c2_sread", s_read, 32'h0);
    tick();
    m0_read = 1'b1; m1_read = 1'b1; m1_address = 24'h000800;
    settle();
    check("t5_c3_owner", owner, 32'h0);
    tick(); settle();
    check("t5_c4_owner", owner, 32'h1);
    check("t5_c4_saddr", s_address, 32'h000700);
    s_stall = 1'b0;
    tick();
    idle_inputs();
    settle();
    check("t5_done_owner", owner, 32'h0);

    // Reset during a stalled m1 transfer restores last = m1
    m1_write = 1'b1; m1_address = 24'h000900; s_stall = 1'b1;
    tick(); settle();
    check("t6_g1_owner", owner, 32'h2);
    m0_read = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    check("t6_rst_owner",   owner,     32'h0);
    check("t6_rst_swrite",  s_write,   32'h0);
    check("t6_rst_sread",   s_read,    32'h0);
    check("t6_rst_saddr",   s_address, 32'h0);
    check("t6_rst_m1stall", m1_stall,  32'h1);
    tick(); settle();
    check("t6_after_owner", owner, 32'h1);

    idle_inputs();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
